// File: rtl/median_win_sched.sv
// rtl/median_win_sched.sv - frame scheduler feeding 3x3 windows to a median unit and writing results
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin one frame (sampled only while idle)
//   busy, done          frame in progress / one-cycle completion pulse
//   rd_en, rd_addr      source frame buffer read strobe and address
//   rd_data             source data, valid the cycle after rd_en
//   win                 9-slot window to the median unit, slot k = [k*DW +: DW]
//   med_en              one-cycle median unit enable
//   med_dout            median unit result, valid MED_LAT cycles after med_en is sampled
//   wr_en, wr_addr      destination frame buffer write strobe and address (y*IMG_W+x)
//   wr_data             destination data: median for interior pixels, centre pixel for border pixels

module median_win_sched #(
    parameter int DW      = 12,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int AW      = 19,
    parameter int MED_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic [9*DW-1:0] win,
    output logic            med_en,
    input  logic [DW-1:0]   med_dout,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW = (MED_LAT > 2) ? $clog2(MED_LAT) : 1;

    localparam logic [AW-1:0] W_A    = AW'(IMG_W);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_FIRE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [3:0]      k;
    logic [AW-1:0]   pix_addr;   // running y*IMG_W+x, advanced once per written pixel
    logic            edge_px;    // current pixel lies on the frame border
    logic [LW-1:0]   wait_cnt;
    logic [DW-1:0]   win_r [9];
    logic [DW-1:0]   wr_data_r;

    logic [XW-1:0]   nxt_x;
    logic [YW-1:0]   nxt_y;
    logic [AW-1:0]   nxt_addr;
    logic            nxt_edge;
    logic            last_px;

    // Offset of window slot kk from the centre address, modulo 2^AW.
    function automatic logic [AW-1:0] slot_off(input logic [3:0] kk);
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        case (kk)
            4'd0, 4'd1, 4'd2: row = '0 - W_A;
            4'd3, 4'd4, 4'd5: row = '0;
            default:          row = W_A;
        endcase
        case (kk)
            4'd0, 4'd3, 4'd6: col = {AW{1'b1}};
            4'd1, 4'd4, 4'd7: col = '0;
            default:          col = AW'(1);
        endcase
        return row + col;
    endfunction

    function automatic logic is_edge(input logic [XW-1:0] xx, input logic [YW-1:0] yy);
        return (xx == '0) || (xx == X_LAST) || (yy == '0) || (yy == Y_LAST);
    endfunction

    for (genvar i = 0; i < 9; i++) begin : g_win
        assign win[i*DW +: DW] = win_r[i];
    end

    // Interior results come straight from the median unit during the write cycle;
    // border pixels use the centre word captured earlier.
    assign wr_data = (wr_en && !edge_px) ? med_dout : wr_data_r;

    always_comb begin
        last_px  = (x == X_LAST) && (y == Y_LAST);
        nxt_x    = x + XW'(1);
        nxt_y    = y;
        if (x == X_LAST) begin
            nxt_x = '0;
            nxt_y = y + YW'(1);
        end
        nxt_addr = pix_addr + AW'(1);
        nxt_edge = is_edge(nxt_x, nxt_y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            x         <= '0;
            y         <= '0;
            k         <= '0;
            pix_addr  <= '0;
            edge_px   <= 1'b0;
            wait_cnt  <= '0;
            for (int i = 0; i < 9; i++) win_r[i] <= '0;
            wr_data_r <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            med_en    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Pixel (0,0) is always a border pixel: only its centre is read.
                        state    <= S_READ;
                        x        <= '0;
                        y        <= '0;
                        k        <= 4'd4;
                        pix_addr <= '0;
                        edge_px  <= 1'b1;
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                    end
                end

                S_READ: begin
                    // Data arriving now belongs to the slot requested last cycle.
                    if (!edge_px && k != 4'd0) win_r[k - 4'd1] <= rd_data;
                    if (edge_px || k == 4'd8) begin
                        state <= S_CAPTURE;
                        rd_en <= 1'b0;
                    end else begin
                        k       <= k + 4'd1;
                        rd_addr <= pix_addr + slot_off(k + 4'd1);
                    end
                end

                S_CAPTURE: begin
                    win_r[k] <= rd_data;
                    if (edge_px) begin
                        state     <= S_WRITE;
                        wr_en     <= 1'b1;
                        wr_addr   <= pix_addr;
                        wr_data_r <= rd_data;
                    end else begin
                        state  <= S_FIRE;
                        med_en <= 1'b1;
                    end
                end

                S_FIRE: begin
                    med_en <= 1'b0;
                    if (MED_LAT <= 1) begin
                        state   <= S_WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= pix_addr;
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= LW'(MED_LAT - 2);
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state   <= S_WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= pix_addr;
                    end else begin
                        wait_cnt <= wait_cnt - LW'(1);
                    end
                end

                S_WRITE: begin
                    wr_en <= 1'b0;
                    if (last_px) begin
                        state    <= S_DONE;
                        x        <= '0;
                        y        <= '0;
                        pix_addr <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state    <= S_READ;
                        x        <= nxt_x;
                        y        <= nxt_y;
                        pix_addr <= nxt_addr;
                        edge_px  <= nxt_edge;
                        k        <= nxt_edge ? 4'd4 : 4'd0;
                        rd_en    <= 1'b1;
                        rd_addr  <= nxt_edge ? nxt_addr : nxt_addr + slot_off(4'd0);
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_win_sched.sv
// tb/tb_median_win_sched.sv - directed bench for median_win_sched on a 4x3 frame

module tb_median_win_sched;

    localparam int DW = 12;
    localparam int IW = 4;
    localparam int IH = 3;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, start_a, busy_a, done_a, rd_en_a, med_en_a, wr_en_a;
    logic [AW-1:0]   rd_addr_a, wr_addr_a;
    logic [DW-1:0]   rd_data_a, med_dout_a, wr_data_a;
    logic [9*DW-1:0] win_a;

    logic            rst_b, start_b, busy_b, done_b, rd_en_b, med_en_b, wr_en_b;
    logic [AW-1:0]   rd_addr_b, wr_addr_b;
    logic [DW-1:0]   rd_data_b, med_dout_b, wr_data_b;
    logic [9*DW-1:0] win_b;

    logic [DW-1:0] mem [0:11];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    median_win_sched #(.DW(DW), .IMG_W(IW), .IMG_H(IH), .AW(AW), .MED_LAT(3)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .win(win_a),
        .med_en(med_en_a), .med_dout(med_dout_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a)
    );

    median_win_sched #(.DW(DW), .IMG_W(IW), .IMG_H(IH), .AW(AW), .MED_LAT(5)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .win(win_b),
        .med_en(med_en_b), .med_dout(med_dout_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b)
    );

    function automatic logic [DW-1:0] median9(input logic [9*DW-1:0] w);
        logic [DW-1:0] v [9];
        logic [DW-1:0] t;
        for (int i = 0; i < 9; i++) v[i] = w[i*DW +: DW];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    // Source RAMs (one read port each) and reference median pipelines.
    logic [DW-1:0] pa [3];
    logic [DW-1:0] pb [5];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en_a) rd_data_a <= mem[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem[rd_addr_b];
        pa[0] <= med_en_a ? median9(win_a) : '1;
        for (int i = 1; i < 3; i++) pa[i] <= pa[i-1];
        pb[0] <= med_en_b ? median9(win_b) : '1;
        for (int i = 1; i < 5; i++) pb[i] <= pb[i-1];
    end
    assign med_dout_a = pa[2];
    assign med_dout_b = pb[4];

    // Activity logs and window-stability tracking.
    int lg_rd_addr[$], lg_rd_cyc[$], lg_wr_addr[$], lg_wr_data[$], lg_wr_cyc[$];
    int lg_done_cyc[$], lg_done_busy[$], lg_rd_cyc_b[$], lg_wr_cyc_b[$];
    int med_cnt, win_err;
    bit pend, have_first;
    logic [9*DW-1:0] snap, first_win;

    always @(negedge clk) begin
        if (rd_en_a) begin lg_rd_addr.push_back(int'(rd_addr_a)); lg_rd_cyc.push_back(cyc); end
        if (wr_en_a) begin
            lg_wr_addr.push_back(int'(wr_addr_a));
            lg_wr_data.push_back(int'(wr_data_a));
            lg_wr_cyc.push_back(cyc);
        end
        if (done_a) begin lg_done_cyc.push_back(cyc); lg_done_busy.push_back(int'(busy_a)); end
        if (rd_en_b) lg_rd_cyc_b.push_back(cyc);
        if (wr_en_b) lg_wr_cyc_b.push_back(cyc);
        if (med_en_a) begin
            med_cnt++;
            snap = win_a;
            pend = 1'b1;
            if (!have_first) begin first_win = win_a; have_first = 1'b1; end
        end else if (pend && busy_a) begin
            if (win_a !== snap) win_err++;
            if (wr_en_a) pend = 1'b0;
        end else begin
            pend = 1'b0;
        end
    end

    task automatic clear_logs();
        lg_rd_addr.delete(); lg_rd_cyc.delete(); lg_wr_addr.delete(); lg_wr_data.delete();
        lg_wr_cyc.delete(); lg_done_cyc.delete(); lg_done_busy.delete();
        lg_rd_cyc_b.delete(); lg_wr_cyc_b.delete();
        med_cnt = 0; win_err = 0; have_first = 1'b0;
    endtask

    task automatic run_frame(input bit poke, input bit use_b);
        bit ga, gb;
        ga = 1'b0; gb = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        start_b = use_b;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_a) ga = 1'b1;
            if (done_b) gb = 1'b1;
            if (ga && (gb || !use_b)) break;
            start_a = poke && (i == 10 || i == 30);
        end
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!ga || (use_b && !gb)) begin
            errors++;
            $display("FAIL frame_timeout got done_a=%0d done_b=%0d exp 1", ga, gb);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; start_a = 1'b1; rst_b = 1'b1; start_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, rd_en_a, med_en_a, wr_en_a} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {busy_a, done_a, rd_en_a, med_en_a, wr_en_a});
        end
        checks++;
        if (rd_addr_a !== '0 || wr_addr_a !== '0) begin
            errors++; $display("FAIL reset_addr got rd=%0d wr=%0d exp 0", rd_addr_a, wr_addr_a);
        end
        checks++;
        if (wr_data_a !== '0) begin errors++; $display("FAIL reset_wr_data got %0d exp 0", wr_data_a); end
        checks++;
        if (win_a !== '0) begin errors++; $display("FAIL reset_win got %h exp 0", win_a); end
        checks++;
        if ({busy_b, done_b, rd_en_b, med_en_b, wr_en_b} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl_b got %b exp 00000", {busy_b, done_b, rd_en_b, med_en_b, wr_en_b});
        end
        rst_a = 1'b0; start_a = 1'b0; rst_b = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || rd_en_a !== 1'b0 || wr_en_a !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy=%0d rd=%0d wr=%0d exp 0", busy_a, rd_en_a, wr_en_a);
        end
    endtask

    task automatic test_frame();
        int exp_rd [28] = '{0, 1, 2, 3, 4,
                            0, 1, 2, 4, 5, 6, 8, 9, 10,
                            1, 2, 3, 5, 6, 7, 9, 10, 11,
                            7, 8, 9, 10, 11};
        for (int i = 0; i < 12; i++) mem[i] = DW'(i);
        clear_logs();
        run_frame(1'b0, 1'b1);
        checks++;
        if (lg_wr_addr.size() != 12) begin errors++; $display("FAIL wr_count got %0d exp 12", lg_wr_addr.size()); end
        for (int i = 0; i < 12 && i < lg_wr_addr.size(); i++) begin
            checks++;
            if (lg_wr_addr[i] != i) begin errors++; $display("FAIL wr_addr[%0d] got %0d exp %0d", i, lg_wr_addr[i], i); end
            // With data == address, every window median equals its centre address.
            checks++;
            if (lg_wr_data[i] != i) begin errors++; $display("FAIL wr_data[%0d] got %0d exp %0d", i, lg_wr_data[i], i); end
        end
        checks++;
        if (lg_rd_addr.size() != 28) begin errors++; $display("FAIL rd_count got %0d exp 28", lg_rd_addr.size()); end
        for (int i = 0; i < 28 && i < lg_rd_addr.size(); i++) begin
            checks++;
            if (lg_rd_addr[i] != exp_rd[i]) begin
                errors++; $display("FAIL rd_addr[%0d] got %0d exp %0d", i, lg_rd_addr[i], exp_rd[i]);
            end
        end
        checks++;
        if (med_cnt != 2) begin errors++; $display("FAIL med_en_count got %0d exp 2", med_cnt); end
        checks++;
        if (win_err != 0) begin errors++; $display("FAIL win_stable got %0d changes exp 0", win_err); end
    endtask

    task automatic test_latency();
        checks++;
        if (lg_wr_cyc.size() < 6 || lg_rd_cyc.size() < 6 || lg_wr_cyc[5] - lg_rd_cyc[5] != 13) begin
            errors++; $display("FAIL lat_interior_3 got %0d exp 13", lg_wr_cyc[5] - lg_rd_cyc[5]);
        end
        checks++;
        if (lg_wr_cyc.size() < 1 || lg_wr_cyc[0] - lg_rd_cyc[0] != 2) begin
            errors++; $display("FAIL lat_border got %0d exp 2", lg_wr_cyc[0] - lg_rd_cyc[0]);
        end
        checks++;
        if (lg_wr_cyc_b.size() < 6 || lg_rd_cyc_b.size() < 6 || lg_wr_cyc_b[5] - lg_rd_cyc_b[5] != 15) begin
            errors++; $display("FAIL lat_interior_5 got %0d exp 15", lg_wr_cyc_b[5] - lg_rd_cyc_b[5]);
        end
        checks++;
        if (lg_wr_cyc_b.size() != 12) begin errors++; $display("FAIL wr_count_b got %0d exp 12", lg_wr_cyc_b.size()); end
    endtask

    task automatic test_restart();
        clear_logs();
        run_frame(1'b1, 1'b0);
        checks++;
        if (lg_wr_addr.size() != 12) begin errors++; $display("FAIL restart_wr_count got %0d exp 12", lg_wr_addr.size()); end
        for (int i = 0; i < 12 && i < lg_wr_addr.size(); i++) begin
            checks++;
            if (lg_wr_addr[i] != i) begin errors++; $display("FAIL restart_addr[%0d] got %0d exp %0d", i, lg_wr_addr[i], i); end
        end
        checks++;
        if (lg_done_cyc.size() != 1) begin errors++; $display("FAIL done_count got %0d exp 1", lg_done_cyc.size()); end
        checks++;
        if (lg_done_cyc.size() < 1 || lg_wr_cyc.size() < 12 || lg_done_cyc[0] != lg_wr_cyc[11] + 1) begin
            errors++; $display("FAIL done_timing got %0d exp %0d", lg_done_cyc[0], lg_wr_cyc[11] + 1);
        end
        checks++;
        if (lg_done_busy.size() < 1 || lg_done_busy[0] != 0) begin
            errors++; $display("FAIL done_busy got %0d exp 0", lg_done_busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit hit;
        n = 0; hit = 1'b0;
        clear_logs();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (med_en_a) n++;
            if (n == 2) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reach_wait got %0d med_en exp 2", n); end
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        checks++;
        if ({busy_a, rd_en_a, med_en_a, wr_en_a, done_a} !== 5'b0 || wr_data_a !== '0 || win_a !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got ctrl=%b wr_data=%0d exp 0",
                               {busy_a, rd_en_a, med_en_a, wr_en_a, done_a}, wr_data_a);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (lg_wr_addr.size() != 6) begin errors++; $display("FAIL aborted_writes got %0d exp 6", lg_wr_addr.size()); end
        clear_logs();
        run_frame(1'b0, 1'b0);
        checks++;
        if (lg_rd_addr.size() < 1 || lg_rd_addr[0] != 0) begin
            errors++; $display("FAIL restart_first_rd got %0d exp 0", lg_rd_addr[0]);
        end
        checks++;
        if (lg_wr_addr.size() != 12 || lg_wr_addr[11] != 11) begin
            errors++; $display("FAIL restart_full_frame got %0d writes exp 12", lg_wr_addr.size());
        end
    endtask

    task automatic test_window();
        int exp_w [9] = '{9, 1, 7, 3, 5, 2, 8, 4, 6};
        mem[0] = 9;  mem[1] = 1;  mem[2] = 7;  mem[3] = 11;
        mem[4] = 3;  mem[5] = 5;  mem[6] = 2;  mem[7] = 13;
        mem[8] = 8;  mem[9] = 4;  mem[10] = 6; mem[11] = 15;
        clear_logs();
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (int'(first_win[i*DW +: DW]) != exp_w[i]) begin
                errors++; $display("FAIL win_slot[%0d] got %0d exp %0d", i, first_win[i*DW +: DW], exp_w[i]);
            end
        end
        checks++;
        if (win_err != 0) begin errors++; $display("FAIL win_frozen got %0d changes exp 0", win_err); end
        checks++;
        if (lg_wr_data.size() < 12 || lg_wr_data[5] != 5) begin
            errors++; $display("FAIL median_11 got %0d exp 5", lg_wr_data[5]);
        end
        checks++;
        if (lg_wr_data.size() < 12 || lg_wr_data[6] != 6) begin
            errors++; $display("FAIL median_21 got %0d exp 6", lg_wr_data[6]);
        end
        checks++;
        if (lg_wr_data.size() < 12 || lg_wr_data[0] != 9 || lg_wr_data[3] != 11 || lg_wr_data[11] != 15) begin
            errors++; $display("FAIL border_copy got %0d/%0d/%0d exp 9/11/15",
                               lg_wr_data[0], lg_wr_data[3], lg_wr_data[11]);
        end
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b0; rst_b = 1'b1; start_b = 1'b0;
        med_cnt = 0; win_err = 0; pend = 1'b0; have_first = 1'b0;
        snap = '0; first_win = '0;
        test_reset();
        test_frame();
        test_latency();
        test_restart();
        test_reset_mid();
        test_window();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
